// File: rtl/uart_host_rx.sv
// uart_host_rx: 8N1 serial receiver with mid-bit sampling feeding a small receive FIFO
module uart_host_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overflow_o,
  output logic       busy_o
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic s1, rxs;
  logic [AW:0] wp, rp;
  logic [7:0] mem [FIFO_DEPTH];
  logic push, pop, full, wr;
  // Two-flop synchronizer; idle-high so both stages reset to 1
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) {rxs, s1} <= 2'b11;
    else {rxs, s1} <= {s1, rx_i};
  // Receive FSM: half-bit delay to the start-bit centre, then one full bit per sample
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (state)
        IDLE:
          if (!rxs) begin
            state <= START;
            cnt <= HALF_BIT;
          end
        START:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (rxs) state <= IDLE;
          else begin
            state <= DATA;
            cnt <= FULL_BIT;
            idx <= '0;
          end
        DATA:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            shreg <= {rxs, shreg[7:1]};
            cnt <= FULL_BIT;
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end
        STOP:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (rxs) state <= IDLE;
          else begin
            state <= WAIT_IDLE;
            frame_err_o <= 1'b1;
          end
        WAIT_IDLE:
          if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  assign busy_o = state != IDLE;
  assign push = state == STOP && cnt == '0 && rxs;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign valid_o = wp != rp;
  assign pop = valid_o & ready_i;
  assign wr = push & (!full | pop);
  assign data_o = valid_o ? mem[rp[AW-1:0]] : '0;
  // FIFO storage; occupancy lives in the pointers so the array needs no reset
  always_ff @(posedge clk_i)
    if (wr) mem[wp[AW-1:0]] <= shreg;
  // FIFO pointers with wrap bit, plus overflow pulse when a full FIFO cannot take the byte
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wp <= '0;
      rp <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      overflow_o <= push & full & !pop;
    end
endmodule

// File: tb/tb_uart_host_rx.sv
// tb_uart_host_rx: directed vectors and corner-case sequences for uart_host_rx
module tb_uart_host_rx;
  logic clk_i = 1'b0, rst_i = 1'b1, rx_i = 1'b1, ready_i = 1'b0;
  logic [7:0] data_o;
  logic valid_o, frame_err_o, overflow_o, busy_o;
  int checks = 0, errors = 0, ferr_cnt = 0, ovf_cnt = 0;
  typedef struct {
    logic [7:0] d;
    bit stop;
    bit exp_valid;
    int exp_ferr;
  } vec_t;
  vec_t tbl[6];
  uart_host_rx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .frame_err_o(frame_err_o), .overflow_o(overflow_o), .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) begin
    if (frame_err_o) ferr_cnt++;
    if (overflow_o) ovf_cnt++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t exceeded limit 2000000", $time);
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic send(input logic [7:0] d, input bit stop, input int rst_bit);
    rx_i = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      if (i == rst_bit) begin
        repeat (8) tick();
        rst_i = 1'b1;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_ferr", frame_err_o, 0);
        chk("rst_ovf", overflow_o, 0);
        tick();
        rx_i = 1'b1;
        rst_i = 1'b0;
        return;
      end
      repeat (16) tick();
    end
    if (stop) begin
      rx_i = 1'b1;
      repeat (16) tick();
    end else begin
      rx_i = 1'b0;
      repeat (40) tick();
      rx_i = 1'b1;
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 60) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy_o, 0);
  endtask
  task automatic pop_chk(input logic [7:0] e);
    chk("pop_valid", valid_o, 1);
    chk("pop_data", data_o, e);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask
  initial begin
    tbl[0] = '{8'h55, 1'b1, 1'b1, 0};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 0};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 0};
    tbl[3] = '{8'hA3, 1'b0, 1'b0, 1};
    tbl[4] = '{8'h3C, 1'b1, 1'b1, 0};
    tbl[5] = '{8'h81, 1'b1, 1'b1, 0};
    repeat (3) tick();
    chk("reset_busy", busy_o, 0);
    chk("reset_valid", valid_o, 0);
    chk("reset_data", data_o, 0);
    chk("reset_ferr", frame_err_o, 0);
    chk("reset_ovf", overflow_o, 0);
    rst_i = 1'b0;
    repeat (2) tick();
    chk("post_reset_busy", busy_o, 0);
    chk("post_reset_valid", valid_o, 0);
    for (int i = 0; i < 6; i++) begin
      ferr_cnt = 0;
      ovf_cnt = 0;
      send(tbl[i].d, tbl[i].stop, -1);
      wait_idle();
      repeat (2) tick();
      chk("tbl_valid", valid_o, tbl[i].exp_valid);
      if (tbl[i].exp_valid) chk("tbl_data", data_o, tbl[i].d);
      chk("tbl_ferr", ferr_cnt, tbl[i].exp_ferr);
      chk("tbl_ovf", ovf_cnt, 0);
      if (tbl[i].exp_valid) begin
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("tbl_drain", valid_o, 0);
      end
    end
    ferr_cnt = 0;
    ovf_cnt = 0;
    fork
      send(8'h55, 1'b1, -1);
      begin
        int n;
        n = 0;
        while (!valid_o && n < 200) begin
          tick();
          n++;
        end
        chk("lat_valid", valid_o, 1);
        chk("lat_bound", 32'(n >= 150 && n <= 156), 1);
        chk("lat_data", data_o, 8'h55);
      end
    join
    chk("lat_ferr", ferr_cnt, 0);
    chk("lat_ovf", ovf_cnt, 0);
    pop_chk(8'h55);
    chk("lat_drain", valid_o, 0);
    ferr_cnt = 0;
    ovf_cnt = 0;
    ready_i = 1'b1;
    rx_i = 1'b0;
    repeat (4) tick();
    rx_i = 1'b1;
    chk("glitch_busy_hi", busy_o, 1);
    begin
      int n;
      n = 4;
      while (busy_o && n < 20) begin
        tick();
        n++;
      end
      chk("glitch_busy_lo", 32'(n <= 12 && !busy_o), 1);
    end
    repeat (20) tick();
    ready_i = 1'b0;
    chk("glitch_valid", valid_o, 0);
    chk("glitch_ferr", ferr_cnt, 0);
    chk("glitch_ovf", ovf_cnt, 0);
    ferr_cnt = 0;
    send(8'hA3, 1'b0, -1);
    chk("ferr_busy_0", busy_o, 1);
    tick();
    chk("ferr_busy_1", busy_o, 1);
    tick();
    chk("ferr_busy_2", busy_o, 1);
    tick();
    chk("ferr_busy_3", busy_o, 0);
    chk("ferr_count", ferr_cnt, 1);
    chk("ferr_valid", valid_o, 0);
    send(8'h3C, 1'b1, -1);
    pop_chk(8'h3C);
    chk("ferr_next_drain", valid_o, 0);
    ovf_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1, -1);
      repeat (2) tick();
      if (i == 4) chk("ovf_before", ovf_cnt, 0);
    end
    chk("ovf_count", ovf_cnt, 1);
    for (int i = 1; i <= 4; i++) pop_chk(8'(i));
    chk("ovf_drain", valid_o, 0);
    ovf_cnt = 0;
    send(8'h11, 1'b1, -1);
    send(8'h22, 1'b1, -1);
    send(8'h33, 1'b1, -1);
    send(8'h44, 1'b1, -1);
    fork
      send(8'h99, 1'b1, -1);
      begin
        repeat (154) tick();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
      end
    join
    chk("fullpp_ovf", ovf_cnt, 0);
    pop_chk(8'h22);
    pop_chk(8'h33);
    pop_chk(8'h44);
    pop_chk(8'h99);
    chk("fullpp_drain", valid_o, 0);
    send(8'h5A, 1'b1, -1);
    chk("prerst_valid", valid_o, 1);
    ferr_cnt = 0;
    ovf_cnt = 0;
    send(8'h7E, 1'b1, 4);
    repeat (30) tick();
    chk("postrst_valid", valid_o, 0);
    chk("postrst_busy", busy_o, 0);
    chk("postrst_ferr", ferr_cnt, 0);
    chk("postrst_ovf", ovf_cnt, 0);
    send(8'hC3, 1'b1, -1);
    pop_chk(8'hC3);
    chk("postrst_drain", valid_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
